decode_stage: RTL and testbench

- Registered instruction-decode pipeline stage for the RV32 core, sitting between fetch and execute.
- Splits the instruction word into fields and generates sign-extended immediates by opcode class.
- Reads the register file, with write-back bypass, and selects operand 2.
- Uses valid/ready handshakes on both sides, with load-use stall and flush support.

---
 rtl/decode_stage_pkg.sv | 64 ++++++
 rtl/decode_stage_if.sv | 48 ++++
 rtl/decode_stage_imm_gen.sv | 29 ++
 rtl/decode_stage.sv | 108 ++++++++++
 tb/tb_decode_stage.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// RV32 decode definitions: opcodes, immediate classes, field layout and decode helpers.
// Shared by decode_stage, imm_gen and decode_stage_if.
package decode_stage_pkg;

   typedef enum logic [6:0] {
      OP       = 7'b0110011,
      OP_IMM   = 7'b0010011,
      LOAD     = 7'b0000011,
      STORE    = 7'b0100011,
      BRANCH   = 7'b1100011,
      JAL      = 7'b1101111,
      JALR     = 7'b1100111,
      LUI      = 7'b0110111,
      AUIPC    = 7'b0010111,
      SYSTEM   = 7'b1110011,
      MISC_MEM = 7'b0001111
   } opcode_t;

   typedef enum logic [2:0] {
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
   } imm_sel_t;

   // Casting the raw instruction word to this struct names every field.
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } ir_fields_t;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] rd;
   } bundle_ctrl_t;

   function automatic imm_sel_t imm_sel_of(input logic [6:0] opcode);
      case (opcode)
         OP_IMM, LOAD, JALR: return IMM_I;
         STORE:              return IMM_S;
         BRANCH:             return IMM_B;
         LUI, AUIPC:         return IMM_U;
         JAL:                return IMM_J;
         default:            return IMM_NONE;
      endcase
   endfunction

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !(opcode inside {LUI, AUIPC, JAL});
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return opcode inside {OP, STORE, BRANCH};
   endfunction

   function automatic logic is_rv32i_opcode(input logic [6:0] opcode);
      return opcode inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
                            LUI, AUIPC, SYSTEM, MISC_MEM};
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, register-file, hazard and execute-side signals of the decode stage.
// slave = the decode stage itself, master = its surroundings.
interface decode_stage_if #(parameter int XLEN = 32);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_ir;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic [4:0]      rf_rs1_addr;
   logic [4:0]      rf_rs2_addr;
   logic [XLEN-1:0] rf_rs1_data;
   logic [XLEN-1:0] rf_rs2_data;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_load;
   logic [4:0]      ex_rd;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_rs1;
   logic [XLEN-1:0] out_rs2;
   logic [XLEN-1:0] out_op2;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_ir, in_pc, flush, rf_rs1_data, rf_rs2_data,
             wb_valid, wb_rd, wb_data, ex_load, ex_rd, out_ready,
      output in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_pc, out_opcode,
             out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_op2, out_imm,
             out_illegal
   );

   modport master (
      output in_valid, in_ir, in_pc, flush, rf_rs1_data, rf_rs2_data,
             wb_valid, wb_rd, wb_data, ex_load, ex_rd, out_ready,
      input  in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_pc, out_opcode,
             out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_op2, out_imm,
             out_illegal
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate and sign-extends it to XLEN.
module imm_gen
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     ir,
   input  imm_sel_t        imm_sel,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves imm32 unassigned (no latch).
      imm32 = '0;
      case (imm_sel)
         IMM_I:   imm32 = {{21{ir[31]}}, ir[30:20]};
         IMM_S:   imm32 = {{21{ir[31]}}, ir[30:25], ir[11:7]};
         IMM_B:   imm32 = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         IMM_U:   imm32 = {ir[31:12], 12'b0};
         IMM_J:   imm32 = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: field split, immediates, bypassed register read, op2 select.
// Define DECODE_ILLEGAL_EN to build the illegal-instruction detector behind out_illegal.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit BYPASS = 1'b1
) (
   input logic           clk,
   input logic           resetn,
   decode_stage_if.slave bus
);

   ir_fields_t      f;
   imm_sel_t        imm_sel;
   logic [XLEN-1:0] imm, rs1_data, rs2_data, op2;
   logic            stall, room, in_ready, accept;

   logic            out_valid_q;
   bundle_ctrl_t    ctrl_q;
   logic [XLEN-1:0] pc_q, rs1_q, rs2_q, op2_q, imm_q;

   assign f               = ir_fields_t'(bus.in_ir);
   assign bus.rf_rs1_addr = f.rs1;
   assign bus.rf_rs2_addr = f.rs2;
   assign imm_sel         = imm_sel_of(f.opcode);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .ir      (bus.in_ir[31:7]),
      .imm_sel (imm_sel),
      .imm     (imm)
   );

   // x0 check comes last so it overrides a bypass hit on wb_rd == 0.
   always_comb begin
      rs1_data = bus.rf_rs1_data;
      rs2_data = bus.rf_rs2_data;
      if (BYPASS && bus.wb_valid && bus.wb_rd == f.rs1) rs1_data = bus.wb_data;
      if (BYPASS && bus.wb_valid && bus.wb_rd == f.rs2) rs2_data = bus.wb_data;
      if (f.rs1 == 5'd0) rs1_data = '0;
      if (f.rs2 == 5'd0) rs2_data = '0;
   end

   assign op2 = (f.opcode == OP || f.opcode == BRANCH) ? rs2_data : imm;

   assign stall = bus.ex_load && bus.ex_rd != 5'd0 &&
                  ((uses_rs1(f.opcode) && bus.ex_rd == f.rs1) ||
                   (uses_rs2(f.opcode) && bus.ex_rd == f.rs2));

   assign room     = !out_valid_q || bus.out_ready;
   assign in_ready = room && !stall && !bus.flush;
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!resetn) begin
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         pc_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         op2_q       <= '0;
         imm_q       <= '0;
      end else begin
         if (bus.flush)  out_valid_q <= 1'b0;
         else if (room)  out_valid_q <= accept;
         if (accept) begin
            ctrl_q <= '{opcode: f.opcode, funct3: f.funct3, funct7: f.funct7, rd: f.rd};
            pc_q   <= bus.in_pc;
            rs1_q  <= rs1_data;
            rs2_q  <= rs2_data;
            op2_q  <= op2;
            imm_q  <= imm;
         end
      end
   end

`ifdef DECODE_ILLEGAL_EN
   logic illegal, illegal_q;

   // Illegal bundles still flow downstream; execute raises the trap.
   assign illegal = !is_rv32i_opcode(f.opcode) || bus.in_ir[1:0] != 2'b11 ||
                    (f.opcode == OP && !(f.funct7 inside {7'h00, 7'h20})) ||
                    (f.opcode == OP && f.funct7 == 7'h20 && !(f.funct3 inside {3'd0, 3'd5}));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     illegal_q <= 1'b0;
      else if (accept) illegal_q <= illegal;
   end

   assign bus.out_illegal = illegal_q;
`else
   assign bus.out_illegal = 1'b0;
`endif

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_pc     = pc_q;
   assign bus.out_opcode = ctrl_q.opcode;
   assign bus.out_funct3 = ctrl_q.funct3;
   assign bus.out_funct7 = ctrl_q.funct7;
   assign bus.out_rd     = ctrl_q.rd;
   assign bus.out_rs1    = rs1_q;
   assign bus.out_rs2    = rs2_q;
   assign bus.out_op2    = op2_q;
   assign bus.out_imm    = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
// Illegal-instruction expectations follow DECODE_ILLEGAL_EN when the bench is built with it.
module tb_decode_stage;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) bus ();

   decode_stage #(.XLEN(32), .BYPASS(1'b1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] opc_list [11];

   // Model state for the random test: what execute should see.
   logic        exp_valid, exp_ill;
   logic [31:0] exp_pc, exp_rs1, exp_rs2, exp_op2, exp_imm;
   logic [6:0]  exp_opc, exp_f7;
   logic [2:0]  exp_f3;
   logic [4:0]  exp_rd;

   function automatic logic [183:0] dut_bundle();
      return {bus.out_valid, bus.out_pc, bus.out_opcode, bus.out_funct3, bus.out_funct7,
              bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_op2, bus.out_imm, bus.out_illegal};
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] ir);
      logic [31:0] sx;
      sx = {32{ir[31]}};
      case (ir[6:0])
         7'h13, 7'h03, 7'h67: return (sx << 11) | 32'(ir[30:20]);
         7'h23:               return (sx << 11) | (32'(ir[30:25]) << 5) | 32'(ir[11:7]);
         7'h63:               return (sx << 12) | (32'(ir[7]) << 11) | (32'(ir[30:25]) << 5)
                                     | (32'(ir[11:8]) << 1);
         7'h37, 7'h17:        return ir & 32'hFFFF_F000;
         7'h6F:               return (sx << 20) | (32'(ir[19:12]) << 12) | (32'(ir[20]) << 11)
                                     | (32'(ir[30:21]) << 1);
         default:             return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_reg(input logic [4:0] addr, input logic [31:0] rf,
                                           input logic wbv, input logic [4:0] wbrd,
                                           input logic [31:0] wbd);
      if (addr == 5'd0) return 32'd0;
      if (wbv && wbrd == addr) return wbd;
      return rf;
   endfunction

   function automatic logic ref_illegal(input logic [31:0] ir);
`ifdef DECODE_ILLEGAL_EN
      logic known;
      known = 1'b0;
      for (int i = 0; i < 11; i++) if (opc_list[i] == ir[6:0]) known = 1'b1;
      if (!known || ir[1:0] != 2'b11) return 1'b1;
      if (ir[6:0] == 7'h33 && ir[31:25] != 7'h00 && ir[31:25] != 7'h20) return 1'b1;
      if (ir[6:0] == 7'h33 && ir[31:25] == 7'h20 && ir[14:12] != 3'd0 && ir[14:12] != 3'd5)
         return 1'b1;
      return 1'b0;
`else
      return (ir == 32'hFFFF_FFFF) && (ir != 32'hFFFF_FFFF);
`endif
   endfunction

   task automatic drive_idle();
      bus.in_valid    = 1'b0;
      bus.in_ir       = 32'h0000_0013;
      bus.in_pc       = 32'd0;
      bus.flush       = 1'b0;
      bus.rf_rs1_data = 32'd0;
      bus.rf_rs2_data = 32'd0;
      bus.wb_valid    = 1'b0;
      bus.wb_rd       = 5'd0;
      bus.wb_data     = 32'd0;
      bus.ex_load     = 1'b0;
      bus.ex_rd       = 5'd0;
      bus.out_ready   = 1'b1;
   endtask

   task automatic test_reset();
      drive_idle();
      resetn = 1'b0;
      #1;
      n_checks++;
      if (dut_bundle() !== 184'd0) $display("FAIL reset_state: got %h expected 0", dut_bundle());
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      bus.in_valid = 1'b1; bus.in_ir = 32'hFFF1_0093; bus.in_pc = 32'h80;
      bus.rf_rs1_data = 32'd5; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL prereset_valid: got %b expected 1", bus.out_valid);
      else n_pass++;
      bus.in_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if (dut_bundle() !== 184'd0) $display("FAIL midstream_reset: got %h expected 0", dut_bundle());
      else n_pass++;
      #2 resetn = 1'b1;
      drive_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      bus.in_valid = 1'b1; bus.in_ir = 32'hFFF1_0093; bus.in_pc = 32'h200;
      bus.rf_rs1_data = 32'd5; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL addi_valid: got %b expected 1", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.out_imm !== 32'hFFFF_FFFF) $display("FAIL addi_imm: got %h expected ffffffff", bus.out_imm);
      else n_pass++;
      n_checks++;
      if (bus.out_op2 !== 32'hFFFF_FFFF) $display("FAIL addi_op2: got %h expected ffffffff", bus.out_op2);
      else n_pass++;
      n_checks++;
      if (bus.out_rs1 !== 32'd5) $display("FAIL addi_rs1: got %h expected 5", bus.out_rs1);
      else n_pass++;
      n_checks++;
      if (bus.out_rd !== 5'd1) $display("FAIL addi_rd: got %0d expected 1", bus.out_rd);
      else n_pass++;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_branch_bypass();
      // BEQ x1, x2, -4 with write-back to x1 in the same cycle.
      bus.in_valid = 1'b1; bus.in_ir = 32'hFE20_8EE3; bus.in_pc = 32'h204;
      bus.rf_rs1_data = 32'h1111; bus.rf_rs2_data = 32'h22;
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hA5;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_imm !== 32'hFFFF_FFFC) $display("FAIL beq_imm: got %h expected fffffffc", bus.out_imm);
      else n_pass++;
      n_checks++;
      if (bus.out_rs1 !== 32'hA5) $display("FAIL beq_bypass_rs1: got %h expected a5", bus.out_rs1);
      else n_pass++;
      n_checks++;
      if (bus.out_op2 !== 32'h22) $display("FAIL beq_op2: got %h expected 22", bus.out_op2);
      else n_pass++;
      // Same branch reading x0; a matching write-back to x0 must not leak through.
      bus.in_ir = 32'hFE20_0EE3; bus.wb_rd = 5'd0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_rs1 !== 32'd0) $display("FAIL beq_x0_rs1: got %h expected 0", bus.out_rs1);
      else n_pass++;
      bus.in_valid = 1'b0; bus.wb_valid = 1'b0;
   endtask

   task automatic test_load_use_stall();
      // ADD x4, x3, x5 behind a load to x3.
      bus.in_valid = 1'b1; bus.in_ir = 32'h0051_8233; bus.in_pc = 32'h208;
      bus.rf_rs1_data = 32'h33; bus.rf_rs2_data = 32'h55;
      bus.ex_load = 1'b1; bus.ex_rd = 5'd3; bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL stall_bubble: got %b expected 0", bus.out_valid);
      else n_pass++;
      bus.ex_load = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL unstall_in_ready: got %b expected 1", bus.in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({bus.out_valid, bus.out_rd, bus.out_rs1, bus.out_op2} !== {1'b1, 5'd4, 32'h33, 32'h55})
         $display("FAIL unstall_accept: got v=%b rd=%0d rs1=%h op2=%h expected v=1 rd=4 rs1=33 op2=55",
                  bus.out_valid, bus.out_rd, bus.out_rs1, bus.out_op2);
      else n_pass++;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_backpressure_flush();
      // ADDI x10, x0, 10 accepted, then execute stalls for three cycles.
      bus.in_valid = 1'b1; bus.in_ir = 32'h00A0_0513; bus.in_pc = 32'h300;
      bus.rf_rs1_data = 32'h77; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0; bus.in_ir = 32'hFFF1_0093; bus.in_pc = 32'h304;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
         else n_pass++;
         @(posedge clk); #1;
         n_checks++;
         if ({bus.out_valid, bus.out_pc, bus.out_rd, bus.out_imm, bus.out_op2, bus.out_rs1} !==
             {1'b1, 32'h300, 5'd10, 32'd10, 32'd10, 32'd0})
            $display("FAIL hold_stable[%0d]: got v=%b pc=%h rd=%0d imm=%h op2=%h rs1=%h expected v=1 pc=300 rd=10 imm=a op2=a rs1=0",
                     i, bus.out_valid, bus.out_pc, bus.out_rd, bus.out_imm, bus.out_op2, bus.out_rs1);
         else n_pass++;
      end
      bus.flush = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bus.out_valid);
      else n_pass++;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
   endtask

   task automatic test_illegal();
      logic exp_flag;
`ifdef DECODE_ILLEGAL_EN
      exp_flag = 1'b1;
`else
      exp_flag = 1'b0;
`endif
      bus.in_valid = 1'b1; bus.in_ir = 32'h0000_0000; bus.in_pc = 32'h400; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({bus.out_valid, bus.out_illegal} !== {1'b1, exp_flag})
         $display("FAIL illegal_zero: got v=%b ill=%b expected v=1 ill=%b",
                  bus.out_valid, bus.out_illegal, exp_flag);
      else n_pass++;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back_random();
      logic [31:0] ir;
      logic [6:0]  opc;
      logic        u1, u2, st, rdy, acc;
      drive_idle();
      resetn = 1'b0;
      #2 resetn = 1'b1;
      {exp_valid, exp_ill} = '0;
      {exp_pc, exp_rs1, exp_rs2, exp_op2, exp_imm} = '0;
      {exp_opc, exp_f7, exp_f3, exp_rd} = '0;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         n_checks++;
         if (dut_bundle() !== {exp_valid, exp_pc, exp_opc, exp_f3, exp_f7, exp_rd,
                               exp_rs1, exp_rs2, exp_op2, exp_imm, exp_ill})
            $display("FAIL rand_bundle[%0d]: got %h expected %h", cyc, dut_bundle(),
                     {exp_valid, exp_pc, exp_opc, exp_f3, exp_f7, exp_rd,
                      exp_rs1, exp_rs2, exp_op2, exp_imm, exp_ill});
         else n_pass++;

         opc = ($urandom_range(0, 15) == 0) ? 7'($urandom) : opc_list[$urandom_range(0, 10)];
         ir = $urandom;
         ir[6:0]   = opc;
         ir[19:15] = 5'($urandom_range(0, 7));
         ir[24:20] = 5'($urandom_range(0, 7));
         if (opc == 7'h33 && $urandom_range(0, 3) != 0)
            ir[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         bus.in_ir       = ir;
         bus.in_valid    = ($urandom_range(0, 4) != 0);
         bus.in_pc       = $urandom;
         bus.rf_rs1_data = $urandom;
         bus.rf_rs2_data = $urandom;
         bus.wb_valid    = $urandom_range(0, 1) == 1;
         bus.wb_rd       = 5'($urandom_range(0, 7));
         bus.wb_data     = $urandom;
         bus.ex_load     = $urandom_range(0, 2) == 0;
         bus.ex_rd       = 5'($urandom_range(0, 7));
         bus.flush       = $urandom_range(0, 9) == 0;
         bus.out_ready   = $urandom_range(0, 9) < 7;
         #1;

         n_checks++;
         if ({bus.rf_rs1_addr, bus.rf_rs2_addr} !== {ir[19:15], ir[24:20]})
            $display("FAIL rand_rf_addr[%0d]: got %0d,%0d expected %0d,%0d", cyc,
                     bus.rf_rs1_addr, bus.rf_rs2_addr, ir[19:15], ir[24:20]);
         else n_pass++;

         u1  = !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6F);
         u2  = (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
         st  = bus.ex_load && bus.ex_rd != 0 &&
               ((u1 && bus.ex_rd == ir[19:15]) || (u2 && bus.ex_rd == ir[24:20]));
         rdy = (!exp_valid || bus.out_ready) && !st && !bus.flush;
         acc = bus.in_valid && rdy;
         n_checks++;
         if (bus.in_ready !== rdy) $display("FAIL rand_in_ready[%0d]: got %b expected %b", cyc, bus.in_ready, rdy);
         else n_pass++;

         if (acc) begin
            exp_pc  = bus.in_pc;
            exp_opc = opc;
            exp_f3  = ir[14:12];
            exp_f7  = ir[31:25];
            exp_rd  = ir[11:7];
            exp_rs1 = ref_reg(ir[19:15], bus.rf_rs1_data, bus.wb_valid, bus.wb_rd, bus.wb_data);
            exp_rs2 = ref_reg(ir[24:20], bus.rf_rs2_data, bus.wb_valid, bus.wb_rd, bus.wb_data);
            exp_imm = ref_imm(ir);
            exp_op2 = (opc == 7'h33 || opc == 7'h63) ? exp_rs2 : exp_imm;
            exp_ill = ref_illegal(ir);
         end
         if (bus.flush) exp_valid = 1'b0;
         else if (!exp_valid || bus.out_ready) exp_valid = acc;

         @(posedge clk); #1;
      end
      drive_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      opc_list = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
      test_reset();
      test_addi();
      test_branch_bypass();
      test_load_use_stall();
      test_backpressure_flush();
      test_illegal();
      test_back_to_back_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
